// File: rtl/lfsr_sequencer_if.sv
// Command channel into the LFSR sequencer: valid/ready handshake carrying an
// opcode and a seed value.
interface lfsr_sequencer_if #(
    parameter int N = 8
);
    logic         CMD_VALID;
    logic         CMD_READY;
    logic [1:0]   CMD_OP;
    logic [N-1:0] CMD_SEED;

    modport master (output CMD_VALID, output CMD_OP, output CMD_SEED, input CMD_READY);
    modport slave  (input CMD_VALID, input CMD_OP, input CMD_SEED, output CMD_READY);
endinterface

// File: rtl/lfsr_sequencer.sv
// Command-driven step/load sequencer for the tapped-shift-register LFSR
// datapath, with programmable step rate and cycle-length measurement.
module lfsr_sequencer #(
    parameter int N    = 8,
    parameter int DIVW = 22
) (
    input  logic            CLK,
    input  logic            RESETN,
    lfsr_sequencer_if.slave cmd,
    input  logic [DIVW-1:0] DIV,
    input  logic [N-1:0]    LFSR_Q,
    output logic            LFSR_CE,
    output logic            LFSR_LOAD,
    output logic [N-1:0]    LFSR_D,
    output logic            RUNNING,
    output logic [N:0]      PERIOD,
    output logic            PERIOD_VALID
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_RUN} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STOP = 2'b10;
    localparam logic [1:0] OP_STEP = 2'b11;

    state_t          state;
    logic [DIVW-1:0] presc;
    logic [N:0]      step_cnt;
    logic [N-1:0]    seed_r;
    logic            seeded;
    logic            ce_p1;
    logic            accept;
    logic            terminal;
    logic            leave_run;

    function automatic logic [N:0] sat_inc(input logic [N:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign cmd.CMD_READY = (state == S_IDLE) || (state == S_RUN);
    assign accept        = cmd.CMD_VALID && cmd.CMD_READY;
    assign terminal      = (state == S_RUN) && (presc >= DIV);
    assign leave_run     = accept && ((cmd.CMD_OP == OP_STOP) || (cmd.CMD_OP == OP_LOAD));

    // A command accepted on a terminal count does not suppress that cycle's step.
    assign LFSR_CE   = terminal || (state == S_STEP);
    assign LFSR_LOAD = (state == S_LOAD);
    assign RUNNING   = (state == S_RUN);
    assign LFSR_D    = seed_r;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= S_IDLE;
            seed_r <= '0;
        end else begin
            case (state)
                S_IDLE, S_RUN: begin
                    if (accept) begin
                        case (cmd.CMD_OP)
                            OP_LOAD: begin
                                state  <= S_LOAD;
                                seed_r <= cmd.CMD_SEED;
                            end
                            OP_RUN:  state <= S_RUN;
                            OP_STOP: state <= S_IDLE;
                            OP_STEP: if (state == S_IDLE) state <= S_STEP;
                            default: state <= state;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            presc <= '0;
        end else if ((state == S_RUN) && !leave_run) begin
            presc <= terminal ? '0 : presc + 1'b1;
        end else begin
            presc <= '0;
        end
    end

    // Stage p1: the datapath has absorbed the previous step, so LFSR_Q is current.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ce_p1        <= 1'b0;
            step_cnt     <= '0;
            seeded       <= 1'b0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
        end else begin
            ce_p1 <= LFSR_CE;
            if (state == S_LOAD) begin
                step_cnt     <= '0;
                seeded       <= 1'b1;
                PERIOD       <= '0;
                PERIOD_VALID <= 1'b0;
            end else begin
                if (LFSR_CE)
                    step_cnt <= sat_inc(step_cnt);
                if (ce_p1 && seeded && !PERIOD_VALID && (LFSR_Q == seed_r)) begin
                    PERIOD       <= step_cnt;
                    PERIOD_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Scoreboard bench for lfsr_sequencer driving a taps-7/5/4/3 LFSR datapath model.
module tb_lfsr_sequencer;

    localparam int N    = 8;
    localparam int DIVW = 22;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STOP = 2'b10;
    localparam logic [1:0] OP_STEP = 2'b11;

    logic            clk = 1'b0;
    logic            RESETN;
    logic [DIVW-1:0] DIV;
    logic [N-1:0]    LFSR_Q;
    logic            LFSR_CE;
    logic            LFSR_LOAD;
    logic [N-1:0]    LFSR_D;
    logic            RUNNING;
    logic [N:0]      PERIOD;
    logic            PERIOD_VALID;

    lfsr_sequencer_if #(.N(N)) cmd_if ();

    lfsr_sequencer #(.N(N), .DIVW(DIVW)) dut (
        .CLK          (clk),
        .RESETN       (RESETN),
        .cmd          (cmd_if),
        .DIV          (DIV),
        .LFSR_Q       (LFSR_Q),
        .LFSR_CE      (LFSR_CE),
        .LFSR_LOAD    (LFSR_LOAD),
        .LFSR_D       (LFSR_D),
        .RUNNING      (RUNNING),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model, with an override so a bench can present arbitrary states.
    logic [N-1:0] q_model = '0;
    logic         force_en;
    logic [N-1:0] force_q;
    always @(posedge clk) begin
        if (LFSR_LOAD)
            q_model <= LFSR_D;
        else if (LFSR_CE)
            q_model <= {q_model[N-2:0], q_model[7] ^ q_model[5] ^ q_model[4] ^ q_model[3]};
    end
    assign LFSR_Q = force_en ? force_q : q_model;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int           exp_ce[$];
    int           exp_ld_cyc[$];
    logic [N-1:0] exp_ld_d[$];
    int           exp_pv_cyc[$];
    int           exp_pv_per[$];
    bit           ready_log[0:4095];

    initial begin : monitor
        int   e;
        logic pv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (RESETN === 1'b1) begin
                if (cyc < 4096) ready_log[cyc] = cmd_if.CMD_READY;
                if (LFSR_CE) begin
                    if (exp_ce.size() > 0) begin
                        e = exp_ce.pop_front();
                        chk("ce_cycle", cyc, e);
                    end else
                        chk("ce_unexpected", cyc, -1);
                end
                if (LFSR_LOAD) begin
                    if (exp_ld_cyc.size() > 0) begin
                        e = exp_ld_cyc.pop_front();
                        chk("load_cycle", cyc, e);
                        chk("load_d", LFSR_D, exp_ld_d.pop_front());
                    end else
                        chk("load_unexpected", cyc, -1);
                end
                if (PERIOD_VALID && !pv_prev) begin
                    if (exp_pv_cyc.size() > 0) begin
                        e = exp_pv_cyc.pop_front();
                        chk("pv_cycle", cyc, e);
                        chk("pv_period", PERIOD, exp_pv_per.pop_front());
                    end else
                        chk("pv_unexpected", cyc, -1);
                end
                pv_prev = PERIOD_VALID;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [1:0] op, input logic [N-1:0] seed, output int acc);
        acc = -1;
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = op;
        cmd_if.CMD_SEED  = seed;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            if (cmd_if.CMD_READY) acc = cyc;
            else @(negedge clk);
        end
        if (acc < 0) begin
            chk("send_timeout", 0, 1);
            cmd_if.CMD_VALID = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_if.CMD_VALID = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c;
        int acc;
        RESETN           = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = OP_STOP;
        cmd_if.CMD_SEED  = '0;
        DIV              = '0;
        force_en         = 1'b0;
        force_q          = '0;
        repeat (3) @(negedge clk);
        chk("rst_ce", LFSR_CE, 0);
        chk("rst_load", LFSR_LOAD, 0);
        chk("rst_running", RUNNING, 0);
        chk("rst_pv", PERIOD_VALID, 0);
        chk("rst_period", PERIOD, 0);
        chk("rst_d", LFSR_D, 0);
        chk("rst_ready", cmd_if.CMD_READY, 1);
        RESETN = 1'b1;
        @(negedge clk);

        // LOAD 0x01
        c = cyc;
        exp_ld_cyc.push_back(c + 1); exp_ld_d.push_back(8'h01);
        send(OP_LOAD, 8'h01, acc);
        chk("load_acc", acc, c);
        chk("load_strobe", LFSR_LOAD, 1);
        chk("load_ready_low", cmd_if.CMD_READY, 0);
        chk("load_pv", PERIOD_VALID, 0);
        @(negedge clk);
        chk("load_strobe_end", LFSR_LOAD, 0);
        chk("load_ready_back", cmd_if.CMD_READY, 1);

        // DIV=3 for 40 cycles
        DIV = 3;
        c = cyc;
        for (int i = 1; i <= 10; i++) exp_ce.push_back(c + 4 * i);
        send(OP_RUN, '0, acc);
        chk("div3_acc", acc, c);
        chk("div3_running", RUNNING, 1);
        while (cyc < c + 40) @(negedge clk);
        send(OP_STOP, '0, acc);
        chk("div3_stop_acc", acc, c + 40);
        chk("div3_running_off", RUNNING, 0);
        repeat (12) @(negedge clk);
        chk("div3_ce_left", exp_ce.size(), 0);

        // Full-period measurement from seed 0x01 at DIV=0
        c = cyc;
        exp_ld_cyc.push_back(c + 1); exp_ld_d.push_back(8'h01);
        send(OP_LOAD, 8'h01, acc);
        @(negedge clk);
        DIV = 0;
        c = cyc;
        for (int i = 1; i <= 555; i++) exp_ce.push_back(c + i);
        exp_pv_cyc.push_back(c + 257); exp_pv_per.push_back(255);
        send(OP_RUN, '0, acc);
        chk("per_pv_low", PERIOD_VALID, 0);
        while (cyc < c + 555) @(negedge clk);
        send(OP_STOP, '0, acc);
        chk("per_stop_acc", acc, c + 555);
        chk("per_period_sticky", PERIOD, 255);
        chk("per_pv_sticky", PERIOD_VALID, 1);
        chk("per_ce_left", exp_ce.size(), 0);
        chk("per_pv_left", exp_pv_cyc.size(), 0);

        // Three back-to-back STEPs; Q forced to the seed only after the third
        force_q  = 8'h00;
        force_en = 1'b1;
        c = cyc;
        exp_ld_cyc.push_back(c + 1); exp_ld_d.push_back(8'hA5);
        send(OP_LOAD, 8'hA5, acc);
        @(negedge clk);
        c = cyc;
        exp_ce.push_back(c + 1); exp_ce.push_back(c + 3); exp_ce.push_back(c + 5);
        exp_pv_cyc.push_back(c + 7); exp_pv_per.push_back(3);
        send(OP_STEP, '0, acc); chk("step1_acc", acc, c);
        send(OP_STEP, '0, acc); chk("step2_acc", acc, c + 2);
        send(OP_STEP, '0, acc); chk("step3_acc", acc, c + 4);
        force_q = 8'hA5;
        repeat (3) @(negedge clk);
        chk("step_count", PERIOD, 3);
        for (int i = 0; i < 6; i++) chk("step_ready_pat", ready_log[c + i], (i % 2 == 0) ? 1 : 0);
        force_en = 1'b0;

        // Lockup seed 0x00
        c = cyc;
        exp_ld_cyc.push_back(c + 1); exp_ld_d.push_back(8'h00);
        send(OP_LOAD, 8'h00, acc);
        @(negedge clk);
        c = cyc;
        exp_ce.push_back(c + 1);
        exp_pv_cyc.push_back(c + 3); exp_pv_per.push_back(1);
        send(OP_STEP, '0, acc);
        repeat (3) @(negedge clk);
        chk("lock_period", PERIOD, 1);
        chk("lock_pv", PERIOD_VALID, 1);

        // STOP on the terminal count at DIV=5
        DIV = 5;
        c = cyc;
        exp_ce.push_back(c + 6);
        send(OP_RUN, '0, acc);
        while (cyc < c + 6) @(negedge clk);
        send(OP_STOP, '0, acc);
        chk("term_stop_acc", acc, c + 6);
        repeat (15) @(negedge clk);
        chk("term_running", RUNNING, 0);
        chk("term_ce_left", exp_ce.size(), 0);

        // Asynchronous reset mid-RUN
        DIV = 0;
        c = cyc;
        for (int i = 1; i <= 10; i++) exp_ce.push_back(c + i);
        send(OP_RUN, '0, acc);
        while (cyc < c + 10) @(negedge clk);
        #2 RESETN = 1'b0;
        #1;
        chk("arst_ce", LFSR_CE, 0);
        chk("arst_running", RUNNING, 0);
        chk("arst_pv", PERIOD_VALID, 0);
        chk("arst_period", PERIOD, 0);
        @(negedge clk);
        @(negedge clk);
        RESETN = 1'b1;
        @(negedge clk);
        chk("arst_ready", cmd_if.CMD_READY, 1);
        chk("arst_idle", RUNNING, 0);
        chk("arst_ce_idle", LFSR_CE, 0);
        chk("arst_ce_left", exp_ce.size(), 0);
        chk("end_load_left", exp_ld_cyc.size(), 0);
        chk("end_pv_left", exp_pv_cyc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
